// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch controller
//
// Purpose: widths, FSM state enum, buffer entry struct and the PC wrap helper
//          used by fetch_controller and fetch_buffer.
// Ports:   none (package).

package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force word alignment, then fold into the ROM address space.
  function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] pc,
                                                input logic [ADDR_W-1:0] rom_bytes);
    return {pc[ADDR_W-1:2], 2'b00} % rom_bytes;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small FIFO of fetched instructions tagged with their PC
//
// Purpose: parameterised-depth FIFO with synchronous flush; push and pop may
//          occur in the same cycle. Flush takes priority over push and pop.
// Ports:
//   i_clock      clock
//   i_reset      synchronous active-high reset
//   i_flush      synchronous clear of all entries
//   i_push       write i_push_entry at the tail
//   i_push_entry entry to write
//   i_pop        remove the head entry (ignored when empty)
//   o_head       head entry (undefined contents when empty)
//   o_count      number of valid entries
//   o_empty      no valid entries
//   o_full       count equals DEPTH

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A full buffer can still accept a push when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, ROM issue and redirect handling for fetch
//
// Purpose: holds the fetch PC, issues word addresses to a registered-read ROM,
//          captures returned words into fetch_buffer and presents them to
//          decode over valid/ready. Redirects flush buffered and in-flight work.
// Ports:
//   i_clock            clock
//   i_reset            synchronous active-high reset
//   o_rom_address      word-aligned byte address to the ROM
//   i_rom_instruction  ROM data, valid the cycle after the address
//   o_inst_valid       buffer head holds an instruction
//   o_inst_data        instruction at the head (zero when empty)
//   o_inst_pc          PC of o_inst_data (zero when empty)
//   i_inst_ready       decode accepts the head this cycle
//   i_redirect_valid   replace the PC and flush
//   i_redirect_pc      new PC (aligned, then wrapped to the ROM size)
//   o_busy             a ROM read is in flight

module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 1024,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_instruction,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_busy
);

  localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ROM_SIZE  = ADDR_W'(ROM_BYTES);
  localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_tag;
  logic              r_inflight;

  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_room;
  logic [CNT_W:0]    w_occ;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;

  assign w_pop = o_inst_valid && i_inst_ready;

  // Occupancy the buffer will have once the outstanding read lands, after
  // this cycle's pop; issuing is only safe if that leaves a free slot.
  assign w_occ  = {1'b0, w_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
  assign w_room = (w_occ < OCC_LIMIT);

  // Returning data is dropped when a flush happens in the same cycle, and in
  // the REDIR cycle that follows a flush.
  assign w_push = r_inflight && (r_state != REDIR) && !i_redirect_valid;

  assign w_push_entry.pc    = r_tag;
  assign w_push_entry.instr = i_rom_instruction;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    if (i_redirect_valid) begin
      w_state_next = REDIR;
    end else begin
      case (r_state)
        RUN: begin
          if (w_room) begin
            w_issue = 1'b1;
          end else begin
            w_state_next = STALL;
          end
        end
        STALL: begin
          if (w_room) begin
            w_state_next = RUN;
          end
        end
        REDIR: begin
          w_state_next = RUN;
        end
        default: begin
          w_state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (i_redirect_valid) begin
        r_fetch_pc <= wrap_pc(i_redirect_pc, ROM_SIZE);
      end else if (w_issue) begin
        r_fetch_pc <= wrap_pc(r_fetch_pc + 32'd4, ROM_SIZE);
      end
      if (w_issue) begin
        r_tag <= r_fetch_pc;
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_entry(w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // The issue rule reserves a slot for every read, so a push never meets a
  // full buffer unless the head is leaving in the same cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      assert (!(w_push && w_full && !w_pop));
    end
  end

  assign o_rom_address = r_fetch_pc;
  assign o_busy        = r_inflight;
  assign o_inst_valid  = !w_empty;
  assign o_inst_data   = w_empty ? 32'd0 : w_head.instr;
  assign o_inst_pc     = w_empty ? 32'd0 : w_head.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller

module tb_fetch_controller;

  localparam logic [31:0] K      = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction = 32'd0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] pops[$];
  int          gap = 0;
  int          max_gap = 0;
  logic        s_valid;
  logic        s_busy;
  logic [31:0] s_pc;
  logic [31:0] s_data;
  logic [31:0] s_addr;

  fetch_controller #(
    .RESET_PC (RST_PC),
    .ROM_BYTES(1024),
    .BUF_DEPTH(2)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .o_rom_address    (rom_address),
    .i_rom_instruction(rom_instruction),
    .o_inst_valid     (inst_valid),
    .o_inst_data      (inst_data),
    .o_inst_pc        (inst_pc),
    .i_inst_ready     (inst_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  // Registered-read ROM: word = address ^ K, one cycle after the address.
  always @(posedge clk) rom_instruction <= rom_address ^ K;

  function automatic logic [31:0] wrapf(input logic [31:0] a);
    return {a[31:2], 2'b00} % 32'd1024;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample one cycle mid-period, score any pop against program order, then
  // advance past the next edge.
  task automatic tick();
    @(negedge clk);
    s_valid = inst_valid;
    s_busy  = busy;
    s_pc    = inst_pc;
    s_data  = inst_data;
    s_addr  = rom_address;
    check("addr_align", {30'd0, rom_address[1:0]}, 32'd0);
    if (rst) begin
      exp_pc = RST_PC;
      gap    = 0;
    end else if (redirect_valid) begin
      exp_pc = wrapf(redirect_pc);
      gap    = 0;
    end else begin
      if (inst_valid && inst_ready) begin
        check("pop_pc", inst_pc, exp_pc);
        check("pop_data", inst_data, exp_pc ^ K);
        pops.push_back(inst_pc);
        exp_pc = wrapf(exp_pc + 32'd4);
      end
      if (inst_valid) begin
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, first-fetch latency and sustained throughput.
    inst_ready = 1'b1;
    do_reset();
    tick();
    check("rst_valid", s_valid, 0);
    check("rst_pc", s_pc, 0);
    check("rst_data", s_data, 0);
    check("rst_busy", s_busy, 0);
    check("rst_addr", s_addr, RST_PC);
    tick();
    check("c1_valid", s_valid, 0);
    check("c1_busy", s_busy, 1);
    check("c1_addr", s_addr, 32'h4);
    pops.delete();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", s_valid, 1);
    end
    check("stream_pops", pops.size(), 8);

    // Decode stalls right at the first valid instruction.
    do_reset();
    tick();
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", s_valid, 1);
      check("stall_pc", s_pc, 32'h0);
      check("stall_addr", s_addr, 32'h8);
    end
    check("stall_busy", s_busy, 0);
    inst_ready = 1'b1;
    pops.delete();
    tick();
    check("release_v0", s_valid, 1);
    tick();
    check("release_v1", s_valid, 1);
    check("release_pops", pops.size(), 2);
    for (int i = 0; i < 10; i++) tick();

    // Redirect to an unaligned target mid-stream.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0027;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("redir_t1_valid", s_valid, 0);
    tick();
    check("redir_t2_addr", s_addr, 32'h24);
    check("redir_t2_valid", s_valid, 0);
    tick();
    check("redir_t3_valid", s_valid, 0);
    check("redir_t3_busy", s_busy, 1);
    tick();
    check("redir_t4_valid", s_valid, 1);
    check("redir_t4_pc", s_pc, 32'h24);
    for (int i = 0; i < 6; i++) tick();

    // Wrap-around at the top of the ROM.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_03F8;
    tick();
    redirect_valid = 1'b0;
    pops.delete();
    for (int i = 0; i < 12; i++) tick();
    check("wrap_count", (pops.size() >= 4) ? 32'd1 : 32'd0, 1);
    if (pops.size() >= 4) begin
      check("wrap_0", pops[0], 32'h3F8);
      check("wrap_1", pops[1], 32'h3FC);
      check("wrap_2", pops[2], 32'h000);
      check("wrap_3", pops[3], 32'h004);
    end

    // Redirect in the same cycle as a pop: the popped entry is flushed.
    tick();
    check("rp_valid_before", s_valid, 1);
    pops.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    check("rp_valid_at_t", s_valid, 1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rp_pops", pops.size(), 1);
    if (pops.size() >= 1) check("rp_first", pops[0], 32'h100);

    // Redirect held several cycles: the last target wins.
    pops.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_pc    = 32'h0000_0250;
    tick();
    redirect_pc    = 32'h0000_031C;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("held_nonempty", (pops.size() >= 1) ? 32'd1 : 32'd0, 1);
    if (pops.size() >= 1) check("held_first", pops[0], 32'h31C);

    // Reset and redirect together: reset wins.
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check("rr_valid", s_valid, 0);
    check("rr_pc", s_pc, 0);
    check("rr_data", s_data, 0);
    check("rr_busy", s_busy, 0);
    check("rr_addr", s_addr, RST_PC);
    tick();
    tick();
    check("rr_c2_valid", s_valid, 1);
    check("rr_c2_pc", s_pc, RST_PC);

    // Reset while a read is in flight: the returning word is dropped.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check("rb_busy", s_busy, 1);
    rst = 1'b0;
    tick();
    check("rb_c0_valid", s_valid, 0);
    tick();
    check("rb_c1_valid", s_valid, 0);
    tick();
    check("rb_c2_valid", s_valid, 1);
    check("rb_c2_pc", s_pc, RST_PC);

    // Random ready, redirects and occasional resets against the order model.
    pops.delete();
    max_gap = 0;
    gap     = 0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    check("rand_max_gap", (max_gap <= 8) ? 32'd1 : 32'd0, 1);
    check("rand_progress", (pops.size() >= 500) ? 32'd1 : 32'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
